// File: rtl/cache_controller.sv
// Blocking set-associative cache controller: one CPU load/store at a time, tag lookup,
// dirty-victim write-back and single-word line refill over a simple memory request port.
module cache_controller #(
  parameter int N_WAYS     = 2,
  parameter int TAG_BITS   = 22,
  parameter int N_POW      = 4,
  parameter int INDEX_BITS = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cpu_req_valid,
  output logic                             cpu_req_ready,
  input  logic                             cpu_req_we,
  input  logic [TAG_BITS+INDEX_BITS+1:0]   cpu_req_addr,
  input  logic [31:0]                      cpu_req_wdata,
  output logic                             cpu_resp_valid,
  output logic [31:0]                      cpu_resp_rdata,
  output logic                             mem_req_valid,
  output logic                             mem_req_we,
  output logic [TAG_BITS+INDEX_BITS+1:0]   mem_req_addr,
  output logic [31:0]                      mem_req_wdata,
  input  logic                             mem_resp_valid,
  input  logic [31:0]                      mem_resp_rdata
);

  localparam int A      = TAG_BITS + INDEX_BITS + 2;
  localparam int N_SETS = 1 << INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    REFILL    = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic                  req_we_q;
  logic [TAG_BITS-1:0]   req_tag_q;
  logic [INDEX_BITS-1:0] req_set_q;
  logic [31:0]           req_wdata_q;
  logic [N_POW-1:0]      victim_q;
  logic                  use_rr_q;
  logic [31:0]           rdata_q;

  logic [TAG_BITS-1:0]   tag_mem  [N_SETS][N_WAYS];
  logic [31:0]           data_mem [N_SETS][N_WAYS];
  logic [N_WAYS-1:0]     valid_q  [N_SETS];
  logic [N_WAYS-1:0]     dirty_q  [N_SETS];
  logic [N_POW-1:0]      rr_q     [N_SETS];

  logic                  hit;
  logic [N_POW-1:0]      hit_way;
  logic [31:0]           hit_data;
  logic                  any_inv;
  logic [N_POW-1:0]      inv_way;
  logic [N_POW-1:0]      victim_way;
  logic                  victim_dirty;
  logic [TAG_BITS-1:0]   wb_tag;
  logic [31:0]           wb_data;
  logic [N_POW-1:0]      rr_next;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^cpu_req_addr[1:0];

  // Lookup: hit detection, lowest-index invalid way, and victim properties.
  always_comb begin
    hit          = 1'b0;
    hit_way      = '0;
    hit_data     = '0;
    any_inv      = 1'b0;
    inv_way      = '0;
    for (int w = 0; w < N_WAYS; w++) begin
      if (valid_q[req_set_q][w] && (tag_mem[req_set_q][w] == req_tag_q)) begin
        hit      = 1'b1;
        hit_way  = N_POW'(w);
        hit_data = data_mem[req_set_q][w];
      end
    end
    for (int w = N_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_set_q][w]) begin
        any_inv = 1'b1;
        inv_way = N_POW'(w);
      end
    end
    victim_way   = any_inv ? inv_way : rr_q[req_set_q];
    victim_dirty = 1'b0;
    wb_tag       = '0;
    wb_data      = '0;
    for (int w = 0; w < N_WAYS; w++) begin
      if (victim_way == N_POW'(w)) begin
        victim_dirty = valid_q[req_set_q][w] && dirty_q[req_set_q][w];
      end
      if (victim_q == N_POW'(w)) begin
        wb_tag  = tag_mem[req_set_q][w];
        wb_data = data_mem[req_set_q][w];
      end
    end
    rr_next = (rr_q[req_set_q] == N_POW'(N_WAYS - 1)) ? '0 : rr_q[req_set_q] + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;
    case (state_q)
      IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit)               state_d = RESPOND;
        else if (victim_dirty) state_d = WRITEBACK;
        else                   state_d = REFILL;
      end
      WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {wb_tag, req_set_q, 2'b00};
        mem_req_wdata = wb_data;
        if (mem_resp_valid) state_d = REFILL;
      end
      REFILL: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag_q, req_set_q, 2'b00};
        if (mem_resp_valid) state_d = RESPOND;
      end
      RESPOND: begin
        cpu_resp_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_resp_rdata = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_we_q    <= 1'b0;
      req_tag_q   <= '0;
      req_set_q   <= '0;
      req_wdata_q <= '0;
      victim_q    <= '0;
      use_rr_q    <= 1'b0;
      rdata_q     <= '0;
      for (int s = 0; s < N_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req_valid) begin
            req_we_q    <= cpu_req_we;
            req_tag_q   <= cpu_req_addr[A-1 -: TAG_BITS];
            req_set_q   <= cpu_req_addr[INDEX_BITS+1:2];
            req_wdata_q <= cpu_req_wdata;
          end
        end
        LOOKUP: begin
          victim_q <= victim_way;
          use_rr_q <= !any_inv;
          if (hit) begin
            if (req_we_q) begin
              rdata_q <= req_wdata_q;
              for (int w = 0; w < N_WAYS; w++) begin
                if (hit_way == N_POW'(w)) dirty_q[req_set_q][w] <= 1'b1;
              end
            end else begin
              rdata_q <= hit_data;
            end
          end
        end
        REFILL: begin
          if (mem_resp_valid) begin
            rdata_q <= req_we_q ? req_wdata_q : mem_resp_rdata;
            for (int w = 0; w < N_WAYS; w++) begin
              if (victim_q == N_POW'(w)) begin
                valid_q[req_set_q][w] <= 1'b1;
                dirty_q[req_set_q][w] <= req_we_q;
              end
            end
            // Round-robin only advances when it actually chose the victim.
            if (use_rr_q) rr_q[req_set_q] <= rr_next;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < N_WAYS; w++) begin
      if (state_q == LOOKUP && hit && req_we_q && hit_way == N_POW'(w)) begin
        data_mem[req_set_q][w] <= req_wdata_q;
      end
      if (state_q == REFILL && mem_resp_valid && victim_q == N_POW'(w)) begin
        tag_mem[req_set_q][w]  <= req_tag_q;
        data_mem[req_set_q][w] <= req_we_q ? req_wdata_q : mem_resp_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: hits, clean/dirty misses, round-robin
// replacement, store-miss refill, spurious acks and reset during refill.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_we;
  logic [31:0] cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        mem_req_valid;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int n_vec = 0;
  int n_err = 0;
  int last_wait;

  cache_controller dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_we    (cpu_req_we),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    int t = 0;
    @(negedge clk);
    while (!cpu_req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready", cpu_req_ready, 1);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wd;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
  endtask

  task automatic mem_serve(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input int dly, input logic [31:0] rd);
    int t = 0;
    @(negedge clk);
    while (!mem_req_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    last_wait = t;
    chk({tag, "_valid"}, mem_req_valid, 1);
    chk({tag, "_we"}, mem_req_we, we);
    chk({tag, "_addr"}, mem_req_addr, addr);
    if (we) chk({tag, "_wdata"}, mem_req_wdata, wd);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {mem_req_valid, mem_req_we, mem_req_addr}, {1'b1, we, addr});
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rd;
    @(posedge clk);
    #1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
  endtask

  task automatic wait_resp(input string tag, input logic [31:0] exp, input int exp_cyc,
                           input logic no_mem);
    int   t = 1;
    logic saw_mem = 1'b0;
    @(negedge clk);
    while (!cpu_resp_valid && t < 40) begin
      saw_mem |= mem_req_valid;
      @(negedge clk);
      t++;
    end
    chk({tag, "_resp"}, cpu_resp_valid, 1);
    chk({tag, "_rdata"}, cpu_resp_rdata, exp);
    chk({tag, "_lat"}, t, exp_cyc);
    if (no_mem) chk({tag, "_nomem"}, saw_mem, 0);
    @(negedge clk);
    chk({tag, "_pulse"}, cpu_resp_valid, 0);
    chk({tag, "_hold"}, cpu_resp_rdata, exp);
  endtask

  initial begin
    logic saw;
    rst            = 1'b1;
    cpu_req_valid  = 1'b0;
    cpu_req_we     = 1'b0;
    cpu_req_addr   = '0;
    cpu_req_wdata  = '0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;

    @(negedge clk);
    chk("rst_ready", cpu_req_ready, 1);
    chk("rst_resp_valid", cpu_resp_valid, 0);
    chk("rst_rdata", cpu_resp_rdata, 0);
    chk("rst_mem", {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Spurious memory ack while idle.
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1 mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("spur_ready", cpu_req_ready, 1);
    chk("spur_memreq", mem_req_valid, 0);
    chk("spur_resp", cpu_resp_valid, 0);

    // Clean miss, memory answers after 3 cycles.
    do_req(1'b0, 32'h0000_1000, 32'h0);
    mem_serve("ld1", 1'b0, 32'h0000_1000, 32'h0, 3, 32'hDEAD_BEEF);
    chk("ld1_reqstart", last_wait, 1);
    wait_resp("ld1", 32'hDEAD_BEEF, 1, 1'b0);

    do_req(1'b0, 32'h0000_1000, 32'h0);
    wait_resp("ld1_hit", 32'hDEAD_BEEF, 2, 1'b1);

    do_req(1'b1, 32'h0000_1000, 32'h1234_5678);
    wait_resp("st_hit", 32'h1234_5678, 2, 1'b1);

    // Fill way 1 of set 0 (invalid way, rr untouched).
    do_req(1'b0, 32'h0040_1000, 32'h0);
    mem_serve("ld2", 1'b0, 32'h0040_1000, 32'h0, 1, 32'h1111_1111);
    wait_resp("ld2", 32'h1111_1111, 1, 1'b0);

    // Set full: rr=0 selects dirty way 0 -> zero-wait write-back, then refill.
    do_req(1'b0, 32'h0080_1000, 32'h0);
    mem_serve("wb", 1'b1, 32'h0000_1000, 32'h1234_5678, 0, 32'h0);
    mem_serve("ld3", 1'b0, 32'h0080_1000, 32'h0, 2, 32'h2222_2222);
    chk("wb_to_refill_gap", last_wait, 0);
    wait_resp("ld3", 32'h2222_2222, 1, 1'b0);

    do_req(1'b0, 32'h0040_1000, 32'h0);
    wait_resp("ld2_hit", 32'h1111_1111, 2, 1'b1);

    // rr now 1: evicts clean way 1, so a refill with no write-back.
    do_req(1'b0, 32'h0000_1000, 32'h0);
    mem_serve("ld4", 1'b0, 32'h0000_1000, 32'h0, 1, 32'h3333_3333);
    wait_resp("ld4", 32'h3333_3333, 1, 1'b0);

    do_req(1'b0, 32'h0080_1000, 32'h0);
    wait_resp("ld3_hit", 32'h2222_2222, 2, 1'b1);

    // Store miss: refill data is discarded in favour of the store data.
    do_req(1'b1, 32'h0000_2004, 32'hA5A5_A5A5);
    mem_serve("stm", 1'b0, 32'h0000_2004, 32'h0, 1, 32'hFFFF_FFFF);
    chk("stm_reqstart", last_wait, 1);
    wait_resp("stm", 32'hA5A5_A5A5, 1, 1'b0);

    do_req(1'b0, 32'h0000_2007, 32'h0);
    wait_resp("stm_hit", 32'hA5A5_A5A5, 2, 1'b1);

    // Reset asserted while the refill request is outstanding.
    do_req(1'b0, 32'h0000_3008, 32'h0);
    begin
      int t = 0;
      @(negedge clk);
      while (!mem_req_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
    end
    chk("rf_pending", {mem_req_valid, mem_req_we, mem_req_addr}, {1'b1, 1'b0, 32'h0000_3008});
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_memreq", mem_req_valid, 0);
    chk("rst_mid_resp", cpu_resp_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw |= cpu_resp_valid | mem_req_valid;
    end
    chk("rst_no_resp", saw, 0);

    do_req(1'b0, 32'h0000_3008, 32'h0);
    mem_serve("post_rst", 1'b0, 32'h0000_3008, 32'h0, 0, 32'h4444_4444);
    wait_resp("post_rst", 32'h4444_4444, 1, 1'b0);

    do_req(1'b0, 32'h0000_2004, 32'h0);
    mem_serve("post_rst2", 1'b0, 32'h0000_2004, 32'h0, 1, 32'h5555_5555);
    wait_resp("post_rst2", 32'h5555_5555, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
